// File: rtl/ramio_pkg.sv
// Shared definitions for the RAMIO responder: request type codes, the
// captured-request record, the FSM state type and the lane helpers.
package ramio_pkg;

  localparam logic [1:0] WriteNone = 2'b00;
  localparam logic [1:0] WriteByte = 2'b01;
  localparam logic [1:0] WriteHalf = 2'b10;
  localparam logic [1:0] WriteWord = 2'b11;

  localparam logic [1:0] ReadNone    = 2'b00;
  localparam logic [1:0] ReadByte    = 2'b01;
  localparam logic [1:0] ReadHalf    = 2'b10;
  localparam logic [1:0] ReadWord    = 2'b11;
  localparam int         ReadSignBit = 2;

  typedef enum logic {
    Idle,
    Wait
  } state_t;

  // One complete request as seen on the port; also the layout of the tag.
  typedef struct packed {
    logic [31:0] address;
    logic [2:0]  read_type;
    logic [1:0]  write_type;
    logic [31:0] data;
  } req_t;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] write_lanes(input logic [1:0] wtype,
                                             input logic [1:0] offset);
    case (wtype)
      WriteByte: write_lanes = 4'b0001 << offset;
      WriteHalf: write_lanes = offset[1] ? 4'b1100 : 4'b0011;
      WriteWord: write_lanes = 4'b1111;
      default:   write_lanes = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] steer_write(input logic [1:0]  wtype,
                                              input logic [31:0] data);
    case (wtype)
      WriteByte: steer_write = {4{data[7:0]}};
      WriteHalf: steer_write = {2{data[15:0]}};
      default:   steer_write = data;
    endcase
  endfunction

  // Pick the addressed byte/half out of a RAM word and sign/zero extend it.
  function automatic logic [31:0] format_read(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  rtype);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic        s;
    shifted = word >> {offset, 3'b000};
    b       = shifted[7:0];
    h       = offset[1] ? word[31:16] : word[15:0];
    s       = rtype[ReadSignBit];
    case (rtype[1:0])
      ReadByte: format_read = {{24{s & b[7]}}, b};
      ReadHalf: format_read = {{16{s & h[15]}}, h};
      ReadWord: format_read = word;
      default:  format_read = word;
    endcase
  endfunction

endpackage

// File: rtl/ramio_bram.sv
// Single-port block RAM, DepthWords x 32, per-byte write enables and a
// registered (one-cycle) read port. Contents are never reset.
module ramio_bram #(
  parameter int DepthWords = 2048,
  parameter int AddrW      = (DepthWords > 1) ? $clog2(DepthWords) : 1
) (
  input  logic             clk,
  input  logic [AddrW-1:0] addr,
  input  logic [3:0]       we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DepthWords];

  // Byte-masked write and read-first registered read on the shared address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ramio_bram_responder.sv
// RAMIO responder: serves byte/half/word loads and stores from block RAM.
// A request is executed once, remembered as a tag, and then reported as
// done (busy low, data_out_ready for loads) for as long as the core keeps
// presenting exactly that request.
// Optional memory-mapped LED register is built when RAMIO_LED_EN is defined.
module ramio_bram_responder #(
  parameter int          DepthWords    = 2048,
  parameter int          LatencyCycles = 1,
  parameter logic [31:0] LedAddress    = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  write_type,
  input  logic [2:0]  read_type,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  output logic        busy,
  output logic [3:0]  led
);

  import ramio_pkg::*;

  localparam int AddrW = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam int CntW  = (LatencyCycles > 1) ? $clog2(LatencyCycles) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LatencyCycles - 1);

  state_t          state, state_nxt;
  logic [CntW-1:0] cnt;
  req_t            req_now, cap_req, tag_q;
  logic            tag_valid;
  logic            live, match, capture, commit;
  logic            led_hit, in_range;
  logic [AddrW-1:0] ram_addr;
  logic [3:0]       ram_we;
  logic [31:0]      ram_wdata, ram_rdata, read_result;

  assign req_now = {address, read_type, write_type, data_in};
  assign live    = enable && ((read_type != 3'b000) || (write_type != WriteNone));
  assign match   = tag_valid && live && (req_now == tag_q);

  assign busy           = (state != Idle) || (live && !match);
  assign data_out_ready = enable && (read_type != 3'b000) && match && (state == Idle);

  // The LED word is never RAM, whether or not the LED register is built.
  assign led_hit  = (cap_req.address[31:2] == LedAddress[31:2]);
  assign in_range = ({2'b00, cap_req.address[31:2]} < 32'(DepthWords)) && !led_hit;

  // While idle the RAM reads the live address so the word is ready by commit.
  assign ram_addr  = (state == Idle) ? address[AddrW+1:2] : cap_req.address[AddrW+1:2];
  assign ram_we    = (commit && in_range) ?
                     write_lanes(cap_req.write_type, cap_req.address[1:0]) : 4'b0000;
  assign ram_wdata = steer_write(cap_req.write_type, cap_req.data);

  ramio_bram #(
    .DepthWords(DepthWords),
    .AddrW     (AddrW)
  ) u_bram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= Idle;
    else        state <= state_nxt;
  end

  // Accept a new request when idle; commit once the latency count runs out.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      Idle: begin
        if (live && !match) begin
          capture   = 1'b1;
          state_nxt = Wait;
        end
      end
      Wait: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = Idle;
        end
      end
      default: state_nxt = Idle;
    endcase
  end

  // Load result for the captured request: RAM lane, LED readback or zero.
  always_comb begin
    read_result = 32'h0;
    if (in_range) read_result = format_read(ram_rdata, cap_req.address[1:0], cap_req.read_type);
`ifdef RAMIO_LED_EN
    if (led_hit) read_result = {28'h0, ~led};
`endif
  end

  // Request capture, latency countdown, tag update and load result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cap_req   <= '0;
      tag_q     <= '0;
      tag_valid <= 1'b0;
      data_out  <= 32'h0;
    end else begin
      if (capture) begin
        cap_req <= req_now;
        cnt     <= CntLoad;
      end else if ((state == Wait) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        tag_q     <= cap_req;
        tag_valid <= 1'b1;
        if (cap_req.write_type == WriteNone) data_out <= read_result;
      end
    end
  end

`ifdef RAMIO_LED_EN
  // LED register takes the inverted low nibble of any store to its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= 4'hF;
    else if (commit && led_hit && (cap_req.write_type != WriteNone)) led <= ~cap_req.data[3:0];
  end
`else
  assign led = 4'hF;
`endif

endmodule

// File: tb/tb_ramio_bram_responder.sv
// Self-checking bench for ramio_bram_responder: directed scenarios followed
// by random loads/stores, all compared against a byte-array memory model.
module tb_ramio_bram_responder;

  localparam int          DEPTH     = 64;
  localparam int          LAT       = 1;
  localparam logic [31:0] LED_ADDR  = 32'hFFFF_FFFC;
  localparam int          MAX_EDGES = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  write_type = 2'b00;
  logic [2:0]  read_type = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic [3:0]  led;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem_model [4*DEPTH];
  logic [3:0]  led_model = 4'hF;
  logic        last_valid = 1'b0;
  logic [68:0] last_req = '0;
  logic [31:0] last_dout = 32'h0;

  ramio_bram_responder #(
    .DepthWords   (DEPTH),
    .LatencyCycles(LAT),
    .LedAddress   (LED_ADDR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .write_type    (write_type),
    .read_type     (read_type),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_out_ready(data_out_ready),
    .busy          (busy),
    .led           (led)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic en, input logic [2:0] rt, input logic [1:0] wt,
                               input logic [31:0] addr, input logic [31:0] din);
    enable     = en;
    read_type  = rt;
    write_type = wt;
    address    = addr;
    data_in    = din;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", name, observed, expected);
    end
  endtask

  // Reference load: assembled byte by byte from the byte-addressed model.
  function automatic logic [31:0] modelRead(input logic [31:0] addr, input logic [2:0] rt);
    int unsigned a;
    logic [7:0]  b;
    logic [15:0] h;
`ifdef RAMIO_LED_EN
    if (addr[31:2] == LED_ADDR[31:2]) return {28'h0, ~led_model};
`endif
    if (32'(addr[31:2]) >= 32'(DEPTH)) return 32'h0;
    a = addr;
    case (rt[1:0])
      2'b01: begin
        b = mem_model[a];
        return rt[2] ? 32'($signed(b)) : 32'(b);
      end
      2'b10: begin
        a = a - (a % 2);
        h = {mem_model[a+1], mem_model[a]};
        return rt[2] ? 32'($signed(h)) : 32'(h);
      end
      default: begin
        a = a - (a % 4);
        return {mem_model[a+3], mem_model[a+2], mem_model[a+1], mem_model[a]};
      end
    endcase
  endfunction

  // Reference store into the byte-addressed model.
  task automatic modelWrite(input logic [31:0] addr, input logic [1:0] wt, input logic [31:0] din);
    int unsigned a;
`ifdef RAMIO_LED_EN
    if (addr[31:2] == LED_ADDR[31:2]) begin
      led_model = ~din[3:0];
      return;
    end
`endif
    if (32'(addr[31:2]) >= 32'(DEPTH)) return;
    a = addr;
    case (wt)
      2'b01: mem_model[a] = din[7:0];
      2'b10: begin
        a = a - (a % 2);
        mem_model[a]   = din[7:0];
        mem_model[a+1] = din[15:8];
      end
      default: begin
        a = a - (a % 4);
        for (int k = 0; k < 4; k++) mem_model[a+k] = din[8*k +: 8];
      end
    endcase
  endtask

  // Present one request, wait for completion and check timing and results.
  task automatic runRequest(input string name, input logic [2:0] rt, input logic [1:0] wt,
                            input logic [31:0] addr, input logic [31:0] din);
    logic [68:0] req;
    logic        repeated;
    int          edges;
    req      = {addr, rt, wt, din};
    repeated = last_valid && (req == last_req);
    @(negedge clk);
    applyStimulus(1'b1, rt, wt, addr, din);
    #1;
    checkOutput({name, ".busy_now"}, 32'(busy), repeated ? 32'd0 : 32'd1);
    checkOutput({name, ".ready_now"}, 32'(data_out_ready), 32'(repeated && (rt != 3'b000)));
    edges = 0;
    while (busy !== 1'b0 && edges < MAX_EDGES) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({name, ".edges"}, 32'(edges), repeated ? 32'd0 : 32'(LAT + 1));
    if (!repeated) begin
      if (wt != 2'b00) modelWrite(addr, wt, din);
      else             last_dout = modelRead(addr, rt);
      last_req   = req;
      last_valid = 1'b1;
    end
    checkOutput({name, ".ready"}, 32'(data_out_ready), 32'(rt != 3'b000));
    if (rt != 3'b000) checkOutput({name, ".data"}, data_out, last_dout);
    checkOutput({name, ".led"}, 32'(led), 32'(led_model));
  endtask

  logic [2:0]  rt_r;
  logic [1:0]  wt_r;
  logic [31:0] addr_r;
  logic [31:0] din_r;
  int          kind;

  // Directed scenarios, then a random mix, then the summary.
  initial begin
    $display("[TB] start: DEPTH=%0d LAT=%0d", DEPTH, LAT);
    #2 rst_n = 1'b0;
    #10;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.ready", 32'(data_out_ready), 32'd0);
    checkOutput("reset.data", data_out, 32'h0);
    checkOutput("reset.led", 32'(led), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) runRequest("init", 3'b000, 2'b11, 32'(4 * i), $urandom);

    runRequest("sw10", 3'b000, 2'b11, 32'h10, 32'h8765_4321);
    runRequest("lw10", 3'b011, 2'b00, 32'h10, 32'h0);
    checkOutput("lw10.const", data_out, 32'h8765_4321);

    runRequest("sb13", 3'b000, 2'b01, 32'h13, 32'h0000_00A5);
    runRequest("lb13", 3'b101, 2'b00, 32'h13, 32'h0);
    checkOutput("lb13.const", data_out, 32'hFFFF_FFA5);
    runRequest("lbu13", 3'b001, 2'b00, 32'h13, 32'h0);
    checkOutput("lbu13.const", data_out, 32'h0000_00A5);
    runRequest("lw10b", 3'b011, 2'b00, 32'h10, 32'h0);
    checkOutput("lw10b.const", data_out, 32'hA565_4321);

    runRequest("sh12", 3'b000, 2'b10, 32'h12, 32'h0000_8001);
    runRequest("lh12", 3'b110, 2'b00, 32'h12, 32'h0);
    checkOutput("lh12.const", data_out, 32'hFFFF_8001);
    runRequest("lhu12", 3'b010, 2'b00, 32'h12, 32'h0);
    checkOutput("lhu12.const", data_out, 32'h0000_8001);
    runRequest("lhu10", 3'b010, 2'b00, 32'h10, 32'h0);
    checkOutput("lhu10.const", data_out, 32'h0000_4321);

    runRequest("lw10c", 3'b011, 2'b00, 32'h10, 32'h0);
    runRequest("lw14", 3'b011, 2'b00, 32'h14, 32'h0);
    runRequest("lw14.again", 3'b011, 2'b00, 32'h14, 32'h0);

    runRequest("oor.read", 3'b011, 2'b00, 32'(4 * DEPTH), 32'h0);
    checkOutput("oor.read.const", data_out, 32'h0);
    runRequest("oor.write", 3'b000, 2'b11, 32'(4 * DEPTH), 32'h1234_5678);
    runRequest("lw0", 3'b011, 2'b00, 32'h0, 32'h0);

    @(negedge clk);
    applyStimulus(1'b1, 3'b000, 2'b11, 32'h20, ~modelRead(32'h20, 3'b011));
    @(posedge clk);
    #1;
    checkOutput("rst.wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    #1;
    checkOutput("rst.ready", 32'(data_out_ready), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.data", data_out, 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    last_valid = 1'b0;
    last_dout  = 32'h0;
    led_model  = 4'hF;
    runRequest("rst.lw20", 3'b011, 2'b00, 32'h20, 32'h0);

    runRequest("led.sw", 3'b000, 2'b11, LED_ADDR, 32'h0000_0005);
`ifdef RAMIO_LED_EN
    checkOutput("led.const", 32'(led), 32'hA);
`else
    checkOutput("led.const", 32'(led), 32'hF);
`endif
    runRequest("led.lw", 3'b011, 2'b00, LED_ADDR, 32'h0);
`ifdef RAMIO_LED_EN
    checkOutput("led.lw.const", data_out, 32'h5);
`else
    checkOutput("led.lw.const", data_out, 32'h0);
`endif

    rt_r   = 3'b011;
    wt_r   = 2'b00;
    addr_r = 32'h0;
    din_r  = 32'h0;
    for (int n = 0; n < 200; n++) begin
      if (n == 0 || $urandom_range(0, 7) != 0) begin
        kind   = int'($urandom_range(0, 9));
        addr_r = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH) + $urandom_range(0, 255)
                                             : $urandom_range(0, 4 * DEPTH - 1);
        din_r  = $urandom;
        rt_r   = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
        wt_r   = 2'($urandom_range(1, 3));
        if (kind < 5)      wt_r = 2'b00;
        else if (kind < 9) rt_r = 3'b000;
      end
      runRequest("rand", rt_r, wt_r, addr_r, din_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
